// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared bus widths, FSM state encoding and owner encoding for
//               the instruction/data memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WEN_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    function automatic logic [DATA_W-1:0] gate_data(input logic en,
                                                    input logic [DATA_W-1:0] d);
        return en ? d : '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/port_grant_logic.sv
// ============================================================================
// Module      : port_grant_logic
// Description : Data-priority grant with a bounded data streak so a waiting
//               instruction request is never starved.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module port_grant_logic
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
    input  logic inst_req,
    input  logic data_req,
    output logic grant_valid,
    output logic grant_owner
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] streak_q;
    logic [CNT_W-1:0] streak_d;
    logic             inst_starved;

    always_comb begin
        inst_starved = inst_req && (streak_q == LIMIT);
        grant_valid  = grant_en && (inst_req || data_req);
        grant_owner  = (data_req && !inst_starved) ? OWNER_DATA : OWNER_INST;
        streak_d     = streak_q;
        // The streak only grows while inst is actually waiting on the port.
        if (grant_valid) begin
            if ((grant_owner == OWNER_DATA) && inst_req) begin
                streak_d = (streak_q == LIMIT) ? streak_q : streak_q + CNT_W'(1);
            end else begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates an instruction and a data requester onto a single
//               SRAM-like port with at most one transaction in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [WEN_W-1:0]  data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic [WEN_W-1:0]  mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state_q,  state_d;
    logic              owner_q,  owner_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [WEN_W-1:0]  wen_q,    wen_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;

    logic grant_en;
    logic grant_valid;
    logic grant_owner;
    logic resp_valid;

    // Gating with rst keeps addr_ok low while reset is held even though IDLE
    // grants are combinational.
    assign grant_en = (state_q == ST_IDLE) && !rst;

    port_grant_logic #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk         (clk),
        .rst         (rst),
        .grant_en    (grant_en),
        .inst_req    (inst_req),
        .data_req    (data_req),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        mem_req      = 1'b0;
        mem_wen      = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        resp_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    if (grant_owner == OWNER_DATA) begin
                        data_addr_ok = 1'b1;
                        addr_d       = data_addr;
                        wen_d        = data_wen;
                        wdata_d      = data_wdata;
                    end else begin
                        inst_addr_ok = 1'b1;
                        addr_d       = inst_addr;
                        wen_d        = '0;
                        wdata_d      = '0;
                    end
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mem_req   = 1'b1;
                mem_wen   = wen_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_data_ok) begin
                    resp_valid = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        inst_data_ok = resp_valid && (owner_q == OWNER_INST);
        data_data_ok = resp_valid && (owner_q == OWNER_DATA);
        inst_rdata   = gate_data(inst_data_ok, mem_rdata);
        data_rdata   = gate_data(data_data_ok, mem_rdata);
        busy         = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_INST;
            addr_q  <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    typedef struct packed {
        logic        inst_req;
        logic [31:0] inst_addr;
        logic        data_req;
        logic [3:0]  data_wen;
        logic [31:0] data_addr;
        logic [31:0] data_wdata;
        logic        mem_addr_ok;
        logic        mem_data_ok;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        inst_addr_ok;
        logic        inst_data_ok;
        logic [31:0] inst_rdata;
        logic        data_addr_ok;
        logic        data_data_ok;
        logic [31:0] data_rdata;
        logic        mem_req;
        logic [3:0]  mem_wen;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        busy;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_addr_ok, data_data_ok;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_addr_ok, mem_data_ok;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wen     (data_wen),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    function automatic in_t mk_in(logic ir, logic [31:0] ia, logic dr, logic [3:0] dw,
                                  logic [31:0] da, logic [31:0] dd, logic mao,
                                  logic mdo, logic [31:0] mrd);
        in_t v;
        v = '{ir, ia, dr, dw, da, dd, mao, mdo, mrd};
        return v;
    endfunction

    function automatic out_t mk_out(logic iao, logic ido, logic [31:0] ird, logic dao,
                                    logic ddo, logic [31:0] drd, logic mr, logic [3:0] mw,
                                    logic [31:0] ma, logic [31:0] md, logic b);
        out_t v;
        v = '{iao, ido, ird, dao, ddo, drd, mr, mw, ma, md, b};
        return v;
    endfunction

    task automatic drive(input in_t v);
        inst_req    = v.inst_req;
        inst_addr   = v.inst_addr;
        data_req    = v.data_req;
        data_wen    = v.data_wen;
        data_addr   = v.data_addr;
        data_wdata  = v.data_wdata;
        mem_addr_ok = v.mem_addr_ok;
        mem_data_ok = v.mem_data_ok;
        mem_rdata   = v.mem_rdata;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic check_out(input string tag, input out_t e);
        check({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(e.inst_addr_ok));
        check({tag, ".inst_data_ok"}, 32'(inst_data_ok), 32'(e.inst_data_ok));
        check({tag, ".inst_rdata"},   inst_rdata,        e.inst_rdata);
        check({tag, ".data_addr_ok"}, 32'(data_addr_ok), 32'(e.data_addr_ok));
        check({tag, ".data_data_ok"}, 32'(data_data_ok), 32'(e.data_data_ok));
        check({tag, ".data_rdata"},   data_rdata,        e.data_rdata);
        check({tag, ".mem_req"},      32'(mem_req),      32'(e.mem_req));
        check({tag, ".mem_wen"},      32'(mem_wen),      32'(e.mem_wen));
        check({tag, ".mem_addr"},     mem_addr,          e.mem_addr);
        check({tag, ".mem_wdata"},    mem_wdata,         e.mem_wdata);
        check({tag, ".busy"},         32'(busy),         32'(e.busy));
    endtask

    localparam int NVEC = 12;
    vec_t vecs [NVEC];
    out_t zero_out;

    initial begin
        zero_out = '0;

        // One record per cycle; inputs applied after the falling edge.
        vecs[0]  = '{mk_in(1, 32'hBFC00000, 0, 4'h0, 0, 0, 0, 0, 0),
                     mk_out(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0)};
        vecs[1]  = '{mk_in(0, 0, 0, 4'h0, 0, 0, 1, 0, 0),
                     mk_out(0, 0, 0, 0, 0, 0, 1, 4'h0, 32'hBFC00000, 0, 1)};
        vecs[2]  = '{mk_in(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h3C080001),
                     mk_out(0, 1, 32'h3C080001, 0, 0, 0, 0, 4'h0, 0, 0, 1)};
        vecs[3]  = '{mk_in(0, 0, 0, 4'h0, 0, 0, 1, 1, 32'h55555555),
                     mk_out(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0)};
        vecs[4]  = '{mk_in(1, 32'h100, 1, 4'hF, 32'h8000, 32'hDEADBEEF, 0, 0, 0),
                     mk_out(0, 0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0)};
        vecs[5]  = '{mk_in(1, 32'h100, 0, 4'h0, 0, 0, 0, 1, 32'h77777777),
                     mk_out(0, 0, 0, 0, 0, 0, 1, 4'hF, 32'h8000, 32'hDEADBEEF, 1)};
        vecs[6]  = '{mk_in(1, 32'h100, 0, 4'h0, 0, 0, 1, 0, 0),
                     mk_out(0, 0, 0, 0, 0, 0, 1, 4'hF, 32'h8000, 32'hDEADBEEF, 1)};
        vecs[7]  = '{mk_in(1, 32'h100, 0, 4'h0, 0, 0, 1, 1, 32'h12345678),
                     mk_out(0, 0, 0, 0, 1, 32'h12345678, 0, 4'h0, 0, 0, 1)};
        vecs[8]  = '{mk_in(1, 32'h100, 0, 4'h0, 0, 0, 0, 0, 0),
                     mk_out(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0)};
        vecs[9]  = '{mk_in(0, 0, 0, 4'h0, 0, 0, 1, 0, 0),
                     mk_out(0, 0, 0, 0, 0, 0, 1, 4'h0, 32'h100, 0, 1)};
        vecs[10] = '{mk_in(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hAABBCCDD),
                     mk_out(0, 1, 32'hAABBCCDD, 0, 0, 0, 0, 4'h0, 0, 0, 1)};
        vecs[11] = '{mk_in(0, 0, 0, 4'h0, 0, 0, 0, 0, 0),
                     mk_out(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0)};

        // Outputs must stay quiet while reset is held, even with a request.
        rst = 1'b1;
        drive(mk_in(1, 32'hBFC00000, 1, 4'hF, 32'h4, 32'h5, 1, 1, 32'h9));
        #2;
        check_out("reset", zero_out);

        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < NVEC; n++) begin
            drive(vecs[n].i);
            #1;
            check_out($sformatf("vec%0d", n), vecs[n].o);
            @(negedge clk);
        end

        // Both requesters held high: expected grant order D,D,I,D,D,I.
        begin
            string exp_order;
            exp_order = "DDIDDI";
            for (int g = 0; g < 6; g++) begin
                logic [7:0] who;
                drive(mk_in(1, 32'h1000 + 32'(g), 1, 4'h0, 32'h2000 + 32'(g), 0, 0, 0, 0));
                #1;
                if (data_addr_ok && !inst_addr_ok)      who = "D";
                else if (inst_addr_ok && !data_addr_ok) who = "I";
                else                                    who = "?";
                check($sformatf("starve_grant%0d", g), 32'(who), 32'(exp_order[g]));
                @(negedge clk);
                mem_addr_ok = 1'b1;
                @(negedge clk);
                mem_addr_ok = 1'b0;
                mem_data_ok = 1'b1;
                @(negedge clk);
                mem_data_ok = 1'b0;
            end
        end

        // Address back-pressure: request and fields held for six ADDR cycles.
        drive(mk_in(0, 0, 1, 4'h3, 32'h40, 32'h11223344, 0, 0, 0));
        #1;
        check("bp_grant", 32'(data_addr_ok), 32'd1);
        @(negedge clk);
        data_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mem_addr_ok = (k == 5);
            mem_data_ok = (k == 2);
            mem_rdata   = 32'hFFFF0000;
            #1;
            check_out($sformatf("bp_addr%0d", k),
                      mk_out(0, 0, 0, 0, 0, 0, 1, 4'h3, 32'h40, 32'h11223344, 1));
            @(negedge clk);
        end
        drive(mk_in(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hCAFEF00D));
        #1;
        check_out("bp_resp", mk_out(0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 4'h0, 0, 0, 1));
        @(negedge clk);

        // Reset while WAIT: the aborted read must never produce data_ok.
        drive(mk_in(1, 32'h200, 0, 4'h0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk_in(0, 0, 0, 4'h0, 0, 0, 1, 0, 0));
        @(negedge clk);
        drive(mk_in(0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
        #1;
        check("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        drive(mk_in(0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h99999999));
        #1;
        check_out("rst_mid", zero_out);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_out("rst_after", zero_out);

        // First grant right after reset release.
        drive(mk_in(1, 32'h300, 0, 4'h0, 0, 0, 0, 1, 32'h99999999));
        #1;
        check_out("post_rst_grant", mk_out(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
        @(negedge clk);
        drive(mk_in(0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
        #1;
        check_out("post_rst_addr", mk_out(0, 0, 0, 0, 0, 0, 1, 4'h0, 32'h300, 0, 1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 2, meaning consecutive data grants allowed while an inst request waits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports inst_req in 1, inst_addr in 32, inst_addr_ok out 1, inst_data_ok out 1, inst_rdata out 32: instruction requester, read-only.
REQ-005 SHALL have ports data_req in 1, data_wen in 4, data_addr in 32, data_wdata in 32, data_addr_ok out 1, data_data_ok out 1, data_rdata out 32: data requester; wen nonzero means store.
REQ-006 SHALL have ports mem_req out 1, mem_wen out 4, mem_addr out 32, mem_wdata out 32, mem_addr_ok in 1, mem_data_ok in 1, mem_rdata in 32: shared downstream SRAM-like port.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE, for the pipeline stall controller.

Function
REQ-008 SHALL implement FSM states IDLE, ADDR, WAIT; at most one transaction outstanding.
REQ-009 IDLE: if any req high, SHALL grant one requester, latch its addr/wen/wdata and owner (inst_wen forced 4'b0), pulse that requester's addr_ok combinationally that cycle, next state ADDR.
REQ-010 Grant rule: data wins over inst, except when inst_req is high and the data-streak counter equals STARVE_LIMIT, then inst wins.
REQ-011 Data-streak counter SHALL increment on each data grant made while inst_req high, clear on any inst grant and on any data grant with inst_req low; saturates at STARVE_LIMIT.
REQ-012 ADDR: mem_req=1 driving latched fields; on mem_addr_ok next state WAIT, else remain ADDR with fields held stable.
REQ-013 WAIT: mem_req=0; on mem_data_ok SHALL assert owner's data_ok for exactly that cycle with rdata = mem_rdata (combinational pass), next state IDLE.
REQ-014 Non-owner data_ok and all addr_ok outside REQ-009 SHALL be 0; rdata outputs SHALL be 0 when corresponding data_ok is 0.
REQ-015 mem_req, mem_wen, mem_addr, mem_wdata SHALL be 0 in IDLE and WAIT.
REQ-016 Minimum grant-to-data_ok latency SHALL be 2 cycles (IDLE grant, ADDR with addr_ok, WAIT with data_ok); no new grant in the data_ok cycle.
REQ-017 Requests arriving while not IDLE SHALL be ignored until IDLE; requesters hold req until their addr_ok.
REQ-018 mem_data_ok in IDLE or ADDR SHALL be ignored; mem_addr_ok outside ADDR SHALL be ignored.
REQ-019 Store transactions SHALL still wait for mem_data_ok before returning to IDLE; data_rdata then carries mem_rdata unmodified.

Reset
REQ-020 rst high SHALL immediately force state IDLE, owner=inst, latched fields 0, streak counter 0, all outputs 0, including mid-transaction; the aborted transaction SHALL produce no data_ok.
REQ-021 First grant SHALL be possible in the first clock edge after rst deasserts.

Structure
REQ-022 State encoding constants and the 1-bit owner encoding (OWNER_INST, OWNER_DATA) SHALL live in the shared defines header alongside existing bus widths.
REQ-023 Grant/anti-starvation logic MAY be a sub-module named port_grant_logic; FSM and latches stay in mem_port_arbiter.

Verification
REQ-024 Inst-only read: inst_req=1 addr 0xBFC00000, mem_addr_ok at ADDR, mem_data_ok next cycle with 0x3C080001 -> inst_addr_ok cycle 0, inst_data_ok cycle 2 with inst_rdata 0x3C080001, busy cycles 1-2.
REQ-025 Simultaneous req: inst addr 0x100, data store wen 4'hF addr 0x8000 wdata 0xDEADBEEF -> data granted first, mem_wen 4'hF mem_wdata 0xDEADBEEF, then inst granted.
REQ-026 Starvation: inst_req and data_req held high continuously, STARVE_LIMIT=2 -> grant order D,D,I,D,D,I.
REQ-027 Back-pressure: mem_addr_ok withheld 5 cycles -> mem_req and fields stable for 6 cycles, no data_ok, busy=1.
REQ-028 Reset mid-WAIT then mem_data_ok -> no data_ok pulse, all outputs 0, state IDLE.
